// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush/bubble sequencing for the 5-stage MIPS pipeline,
//               with load-use detection and a mul/div busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_rd,
    input  logic             ex_md_start,
    input  logic             branch_taken,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_enable,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MD_BUSY    = 2'd2
    } state_t;

    localparam logic [4:0] c_md_reload = 5'(MD_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_md_cnt;
    logic [4:0]       w_md_cnt_next;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_md_busy;
    logic             w_load_use;
    logic             w_hilo_wait;

    always_comb begin
        w_md_busy     = 1'b0;
        w_load_use    = 1'b0;
        w_hilo_wait   = 1'b0;
        w_md_cnt_next = 5'd0;
        w_state_next  = S_RUN;
        pc_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_enable  = 1'b0;

        w_md_busy   = !reset && (r_md_cnt != 5'd0);
        w_hilo_wait = w_md_busy && id_uses_hilo;
        // The bubble inserted on the previous cycle already sits in EX.
        w_load_use  = ex_mem_rd && (ex_rt != 5'd0) && (r_state != S_LOAD_STALL) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

        if (ex_md_start && !branch_taken) begin
            w_md_cnt_next = c_md_reload;
        end else if (r_md_cnt != 5'd0) begin
            w_md_cnt_next = r_md_cnt - 5'd1;
        end

        if (reset) begin
            pc_stall     = 1'b1;
            IF_ID_flush  = 1'b1;
            ID_EX_enable = 1'b1;
        end else if (branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_enable = 1'b1;
        end else if (w_hilo_wait || w_load_use) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_enable = 1'b1;
        end

        if (!branch_taken && !ex_md_start && !w_hilo_wait &&
            w_load_use && (r_state == S_RUN)) begin
            w_state_next = S_LOAD_STALL;
        end else if (w_md_cnt_next != 5'd0) begin
            w_state_next = S_MD_BUSY;
        end else begin
            w_state_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_md_cnt       <= 5'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
            if (pc_stall && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign md_busy      = w_md_busy;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives the stall/bubble enables of PC, IF_ID and ID_EX. Detects load-use hazards against the instruction held in ID_EX, flushes on taken branch/jump, and scoreboards the multi-cycle mul/div unit so HI/LO readers wait. Sits beside the decoder; outputs are consumed by the pipeline registers, which latch on negedge clk.

Parameters:
MD_CYCLES, 8, mul/div latency in cycles (2..31)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  system clock; state updates on posedge
reset  in  1  synchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_uses_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo or mul/div
ex_rt  in  5  rt_out of ID_EX (load destination)
ex_mem_rd  in  1  flag_mem_rd_out of ID_EX (instruction in EX is a load)
ex_md_start  in  1  instruction in EX is mult/multu/div/divu
branch_taken  in  1  EX resolved taken branch or jump
pc_stall  out  1  1 = PC holds
IF_ID_stall  out  1  1 = IF_ID holds
IF_ID_flush  out  1  1 = IF_ID loads NOP
ID_EX_enable  out  1  0 = ID_EX loads normally, 1 = ID_EX inserts bubble
md_busy  out  1  mul/div unit in progress
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- State register (posedge clk): RUN, LOAD_STALL, MD_BUSY; md_cnt 5 bits.
- Outputs pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_enable are combinational from state + inputs (settle before negedge latch).
- Reset (reset=1 at posedge): state=RUN, md_cnt=0, stall_cycles=0. While reset asserted: pc_stall=1, IF_ID_stall=0, IF_ID_flush=1, ID_EX_enable=1 (pipe fills with bubbles); md_busy=0.
- load_use = ex_mem_rd & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- hilo_wait = md_busy & id_uses_hilo.
- Priority per cycle: branch_taken > hilo_wait > load_use > none.
  - branch_taken: IF_ID_flush=1, ID_EX_enable=1, pc_stall=0, IF_ID_stall=0; next state RUN if no md pending, else MD_BUSY; any LOAD_STALL cancelled.
  - hilo_wait: pc_stall=1, IF_ID_stall=1, ID_EX_enable=1.
  - load_use in RUN: pc_stall=1, IF_ID_stall=1, ID_EX_enable=1; next LOAD_STALL.
  - none: all four outputs 0.
- LOAD_STALL lasts exactly one cycle; load_use is suppressed in it (bubble already in EX); returns to RUN (or MD_BUSY if md_cnt!=0).
- ex_md_start=1 at posedge (and branch_taken=0): md_cnt loaded with MD_CYCLES-1, state MD_BUSY. md_busy = (md_cnt!=0).
- MD_BUSY: md_cnt decrements each posedge; at 1->0 state returns RUN. Load-use detection remains active in MD_BUSY (same stall rules, state stays MD_BUSY, counter keeps running).
- ex_md_start while md_busy: counter reloads to MD_CYCLES-1 (back-to-back mul/div restart).
- stall_cycles increments each posedge where pc_stall=1 and reset=0; saturates at all-ones, never wraps.
- Reset mid-operation: aborts MD_BUSY/LOAD_STALL immediately on that edge.

Test Plan:
- Hold reset 3 cycles -> pc_stall=1, IF_ID_flush=1, ID_EX_enable=1; after release with idle inputs all four = 0, stall_cycles=0 (reset cycles not counted).
- ex_mem_rd=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> one cycle pc_stall=IF_ID_stall=ID_EX_enable=1, then 0 next cycle even if inputs held; stall_cycles=1.
- Same as above with ex_rt=0 -> no stall.
- ex_md_start pulse, MD_CYCLES=8, id_uses_hilo=1 -> md_busy=1 for 7 cycles, pc_stall=1 for those 7, released on 8th; stall_cycles=7.
- branch_taken=1 coincident with load_use -> IF_ID_flush=1, ID_EX_enable=1, pc_stall=0; next cycle not LOAD_STALL.
- Force 2^CNT_W+5 stall cycles -> stall_cycles holds 0xFFFF.
